// File: rtl/mgmt_multi_timer.sv
// ============================================================================
// Module   : mgmt_multi_timer
// Purpose  : NCH-channel up/down counter/timer with cascade chaining, sticky
//            IRQ and word-addressed register slave. Optional per-channel
//            prescaler enabled by MGMT_MULTI_TIMER_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mgmt_multi_timer #(
    parameter int NCH   = 2,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_we,
    input  logic [AW-1:0]     reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic [NCH-1:0]    irq,
    output logic [NCH-1:0]    evt
);

    localparam int               c_sel_w      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [1:0]       c_reg_config = 2'd0;
    localparam logic [1:0]       c_reg_value  = 2'd1;
    localparam logic [1:0]       c_reg_data   = 2'd2;
    localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [c_sel_w-1:0]    w_sel;
    logic                  w_sel_ok;
    logic [NCH-1:0][31:0]  w_cfg_rd;
    logic [NCH-1:0][31:0]  w_val_rd;
    logic [NCH-1:0][31:0]  w_dat_rd;
    logic [NCH-1:0]        w_st_rd;
    logic                  w_unused_wdata;

    assign w_unused_wdata = ^reg_wdata;

    generate
        if (NCH > 1) begin : g_sel_multi
            assign w_sel    = reg_addr[AW-1:2];
            assign w_sel_ok = (int'(w_sel) < NCH);
        end else begin : g_sel_single
            assign w_sel    = 1'b0;
            assign w_sel_ok = 1'b1;
        end
    endgenerate

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic             r_en;
            logic             r_oneshot;
            logic             r_up;
            logic             r_chain;
            logic             r_irq_en;
            logic             r_status;
            logic [WIDTH-1:0] r_value;
            logic [WIDTH-1:0] r_data;
            logic [7:0]       w_prescale;
            logic             w_hit;
            logic             w_wr_cfg;
            logic             w_wr_val;
            logic             w_wr_dat;
            logic             w_wr_st;
            logic             w_ptick;
            logic             w_src;
            logic             w_kill;
            logic             w_tick;
            logic             w_term;
            logic             w_evt_ch;

            assign w_hit    = reg_we && w_sel_ok && (int'(w_sel) == k);
            assign w_wr_cfg = w_hit && (reg_addr[1:0] == c_reg_config);
            assign w_wr_val = w_hit && (reg_addr[1:0] == c_reg_value);
            assign w_wr_dat = w_hit && (reg_addr[1:0] == c_reg_data);
            assign w_wr_st  = w_hit && (reg_addr[1:0] == 2'd3);

`ifdef MGMT_MULTI_TIMER_PRESCALE_EN
            logic [7:0] r_prescale;
            logic [7:0] r_pcount;

            assign w_prescale = r_prescale;
            assign w_ptick    = (r_pcount == r_prescale);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_prescale <= 8'd0;
                    r_pcount   <= 8'd0;
                end else begin
                    if (!r_en || w_ptick) begin
                        r_pcount <= 8'd0;
                    end else begin
                        r_pcount <= r_pcount + 8'd1;
                    end
                    if (w_wr_cfg) begin
                        r_prescale <= reg_wdata[15:8];
                    end
                end
            end
`else
            assign w_prescale = 8'd0;
            assign w_ptick    = 1'b1;
`endif

            // Cascade is zero-latency: this channel sees the previous event in the same cycle.
            if (k > 0) begin : g_cascade
                assign w_src = r_chain ? g_ch[k-1].w_evt_ch : w_ptick;
            end else begin : g_root
                assign w_src = w_ptick;
            end

            // A VALUE write, or a CONFIG write clearing enable, pre-empts the tick.
            assign w_kill   = w_wr_val || (w_wr_cfg && !reg_wdata[0]);
            assign w_tick   = r_en && w_src && !w_kill;
            assign w_term   = r_up ? (r_value == r_data) : (r_value == '0);
            assign w_evt_ch = w_tick && w_term;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_en      <= 1'b0;
                    r_oneshot <= 1'b0;
                    r_up      <= 1'b0;
                    r_chain   <= 1'b0;
                    r_irq_en  <= 1'b0;
                    r_status  <= 1'b0;
                    r_value   <= '0;
                    r_data    <= '0;
                end else begin
                    if (w_tick) begin
                        if (!w_term) begin
                            r_value <= r_up ? (r_value + c_one) : (r_value - c_one);
                        end else if (!r_oneshot) begin
                            r_value <= r_up ? '0 : r_data;
                        end else begin
                            r_en <= 1'b0;
                        end
                    end
                    if (w_wr_val) begin
                        r_value <= reg_wdata[WIDTH-1:0];
                    end
                    if (w_wr_dat) begin
                        r_data <= reg_wdata[WIDTH-1:0];
                    end
                    if (w_wr_cfg) begin
                        r_en      <= reg_wdata[0];
                        r_oneshot <= reg_wdata[1];
                        r_up      <= reg_wdata[2];
                        r_chain   <= reg_wdata[3];
                        r_irq_en  <= reg_wdata[4];
                    end
                    if (w_evt_ch) begin
                        r_status <= 1'b1;
                    end else if (w_wr_st && reg_wdata[0]) begin
                        r_status <= 1'b0;
                    end
                end
            end

            assign w_cfg_rd[k] = {16'd0, w_prescale, 3'd0, r_irq_en, r_chain, r_up, r_oneshot, r_en};
            assign w_val_rd[k] = 32'(r_value);
            assign w_dat_rd[k] = 32'(r_data);
            assign w_st_rd[k]  = r_status;
            assign evt[k]      = w_evt_ch;
            assign irq[k]      = r_status && r_irq_en;
        end
    endgenerate

    always_comb begin
        reg_rdata = 32'd0;
        if (w_sel_ok) begin
            case (reg_addr[1:0])
                c_reg_config: reg_rdata = w_cfg_rd[w_sel];
                c_reg_value:  reg_rdata = w_val_rd[w_sel];
                c_reg_data:   reg_rdata = w_dat_rd[w_sel];
                default:      reg_rdata = {31'd0, w_st_rd[w_sel]};
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mgmt_multi_timer.sv
// ============================================================================
// Module   : tb_mgmt_multi_timer
// Purpose  : Directed self-checking bench for mgmt_multi_timer (32-bit and
//            8-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mgmt_multi_timer;

`ifdef MGMT_MULTI_TIMER_PRESCALE_EN
    localparam bit c_pre = 1'b1;
`else
    localparam bit c_pre = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [1:0]  irq;
    logic [1:0]  evt;

    logic        we8;
    logic [2:0]  addr8;
    logic [31:0] wdata8;
    logic [31:0] rdata8;
    logic [1:0]  irq8;
    logic [1:0]  evt8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mgmt_multi_timer #(.NCH(2), .WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq), .evt(evt)
    );

    mgmt_multi_timer #(.NCH(2), .WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .reg_we(we8), .reg_addr(addr8),
        .reg_wdata(wdata8), .reg_rdata(rdata8), .irq(irq8), .evt(evt8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
    endtask

    task automatic wr8(input logic [2:0] a, input logic [31:0] d);
        we8 = 1'b1; addr8 = a; wdata8 = d;
        @(posedge clk);
        #1;
        we8 = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic rd8(input logic [2:0] a, output logic [31:0] d);
        addr8 = a;
        #1;
        d = rdata8;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d: got %0h want 0", a, d); end
        end
        n_cmp++; if (irq !== 2'b00) begin n_bad++; $display("FAIL reset_irq: got %b want 00", irq); end
        n_cmp++; if (evt !== 2'b00) begin n_bad++; $display("FAIL reset_evt: got %b want 00", evt); end
    endtask

    task automatic test_down_continuous();
        logic [31:0] d;
        int first, second, pulses;
        first = -1; second = -1; pulses = 0;
        wr(3'd2, 32'h19);
        wr(3'd1, 32'h19);
        wr(3'd0, 32'h11);
        for (int n = 0; n < 60; n++) begin
            if (evt[0]) begin
                pulses++;
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            step();
        end
        n_cmp++; if (first !== 25) begin n_bad++; $display("FAIL down_first_evt: got %0d want 25", first); end
        n_cmp++; if (second !== 51) begin n_bad++; $display("FAIL down_second_evt: got %0d want 51", second); end
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL down_pulses: got %0d want 2", pulses); end
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL down_status_set: got %0h want 1", d); end
        n_cmp++; if (irq[0] !== 1'b1) begin n_bad++; $display("FAIL down_irq_set: got %b want 1", irq[0]); end
        wr(3'd3, 32'd1);
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL down_status_clr: got %0h want 0", d); end
        n_cmp++; if (irq[0] !== 1'b0) begin n_bad++; $display("FAIL down_irq_clr: got %b want 0", irq[0]); end
        wr(3'd0, 32'd0);
    endtask

    task automatic test_up_oneshot();
        logic [31:0] d;
        int first, pulses;
        first = -1; pulses = 0;
        wr(3'd2, 32'h0F);
        wr(3'd1, 32'h00);
        wr(3'd0, 32'h07);
        for (int n = 0; n < 25; n++) begin
            if (evt[0]) begin
                pulses++;
                if (first < 0) first = n;
            end
            step();
        end
        n_cmp++; if (first !== 15) begin n_bad++; $display("FAIL oneshot_evt_at: got %0d want 15", first); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL oneshot_pulses: got %0d want 1", pulses); end
        rd(3'd1, d);
        n_cmp++; if (d !== 32'h0F) begin n_bad++; $display("FAIL oneshot_value: got %0h want f", d); end
        rd(3'd0, d);
        n_cmp++; if (d !== 32'h06) begin n_bad++; $display("FAIL oneshot_config: got %0h want 6", d); end
        wr(3'd3, 32'd1);
    endtask

    task automatic test_chain();
        logic [31:0] d;
        int cnt0, cnt1, first1, second1, lone1;
        cnt0 = 0; cnt1 = 0; first1 = -1; second1 = -1; lone1 = 0;
        wr(3'd2, 32'd3);
        wr(3'd1, 32'd3);
        wr(3'd6, 32'd2);
        wr(3'd5, 32'd2);
        wr(3'd4, 32'h09);
        wr(3'd0, 32'h01);
        for (int n = 0; n < 30; n++) begin
            if (evt[0]) cnt0++;
            if (evt[1]) begin
                cnt1++;
                if (!evt[0]) lone1++;
                if (first1 < 0) first1 = n;
                else if (second1 < 0) second1 = n;
            end
            if (n == 5) begin
                rd(3'd5, d);
                n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL chain_ch1_value: got %0h want 1", d); end
            end
            step();
        end
        n_cmp++; if (cnt0 !== 7) begin n_bad++; $display("FAIL chain_evt0_count: got %0d want 7", cnt0); end
        n_cmp++; if (cnt1 !== 2) begin n_bad++; $display("FAIL chain_evt1_count: got %0d want 2", cnt1); end
        n_cmp++; if (first1 !== 11) begin n_bad++; $display("FAIL chain_evt1_first: got %0d want 11", first1); end
        n_cmp++; if (second1 !== 23) begin n_bad++; $display("FAIL chain_evt1_second: got %0d want 23", second1); end
        n_cmp++; if (lone1 !== 0) begin n_bad++; $display("FAIL chain_coincide: got %0d want 0", lone1); end
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd0);
        wr(3'd3, 32'd1);
        wr(3'd7, 32'd1);
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        int first;
        first = -1;
        wr(3'd2, 32'd10);
        wr(3'd1, 32'd10);
        wr(3'd0, 32'h401);
        for (int n = 0; n < 60; n++) begin
            if (evt[0] && first < 0) first = n;
            if (n == 5) begin
                rd(3'd1, d);
                n_cmp++; if (d !== (c_pre ? 32'd9 : 32'd5)) begin n_bad++; $display("FAIL prescale_value_n5: got %0d want %0d", d, c_pre ? 9 : 5); end
            end
            step();
        end
        n_cmp++; if (first !== (c_pre ? 54 : 10)) begin n_bad++; $display("FAIL prescale_evt_at: got %0d want %0d", first, c_pre ? 54 : 10); end
        rd(3'd0, d);
        n_cmp++; if (d !== (c_pre ? 32'h401 : 32'h001)) begin n_bad++; $display("FAIL prescale_config: got %0h want %0h", d, c_pre ? 32'h401 : 32'h001); end
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd1);
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        wr(3'd0, 32'h01);
        wr(3'd1, 32'h12BC);
        rd(3'd1, d);
        n_cmp++; if (d !== 32'h12BC) begin n_bad++; $display("FAIL coll_value_write: got %0h want 12bc", d); end
        step();
        rd(3'd1, d);
        n_cmp++; if (d !== 32'h12BB) begin n_bad++; $display("FAIL coll_tick_resume: got %0h want 12bb", d); end
        wr(3'd1, 32'd2);
        step();
        step();
        n_cmp++; if (evt[0] !== 1'b1) begin n_bad++; $display("FAIL coll_evt_due: got %b want 1", evt[0]); end
        wr(3'd3, 32'd1);
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL coll_status_kept: got %0h want 1", d); end
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int bad_evt;
        bad_evt = 0;
        wr(3'd2, 32'h55);
        wr(3'd1, 32'h01);
        wr(3'd0, 32'h11);
        step();
        step();
        step();
        n_cmp++; if (irq[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_irq_before: got %b want 1", irq[0]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), d);
            n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rstmid_reg%0d: got %0h want 0", a, d); end
        end
        n_cmp++; if (irq !== 2'b00) begin n_bad++; $display("FAIL rstmid_irq: got %b want 00", irq); end
        for (int n = 0; n < 4; n++) begin
            if (evt !== 2'b00) bad_evt++;
            step();
        end
        n_cmp++; if (bad_evt !== 0) begin n_bad++; $display("FAIL rstmid_evt: got %0d want 0", bad_evt); end
    endtask

    task automatic test_width8_wrap();
        logic [31:0] d;
        int first, pulses;
        first = -1; pulses = 0;
        wr8(3'd2, 32'h10);
        wr8(3'd1, 32'hABCDEFFF);
        rd8(3'd1, d);
        n_cmp++; if (d !== 32'h000000FF) begin n_bad++; $display("FAIL w8_value_trunc: got %0h want ff", d); end
        wr8(3'd0, 32'h05);
        for (int n = 0; n < 21; n++) begin
            if (evt8[0]) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (n == 1 || n == 17 || n == 18) begin
                rd8(3'd1, d);
                n_cmp++; if (d !== (n == 17 ? 32'h10 : 32'h00)) begin n_bad++; $display("FAIL w8_value_n%0d: got %0h want %0h", n, d, n == 17 ? 32'h10 : 32'h00); end
            end
            step();
        end
        n_cmp++; if (first !== 17) begin n_bad++; $display("FAIL w8_evt_at: got %0d want 17", first); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL w8_pulses: got %0d want 1", pulses); end
    endtask

    initial begin
        reset = 1'b1; reg_we = 1'b0; reg_addr = 3'd0; reg_wdata = 32'd0;
        we8 = 1'b0; addr8 = 3'd0; wdata8 = 32'd0;
        test_reset();
        test_down_continuous();
        test_up_oneshot();
        test_chain();
        test_prescale();
        test_collisions();
        test_reset_mid();
        test_width8_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mgmt_multi_timer.md
Name: mgmt_multi_timer

Overview:
- Parametrised multi-channel counter/timer for the management SoC; successor to the single 32-bit counter/timer.
- Provides NCH independent channels of WIDTH bits, each with up/down count, one-shot or continuous mode, cascade chaining to the previous channel, and a sticky IRQ.
- Sits on the SoC register bus as a simple word-addressed slave; IRQ lines go to the CPU interrupt controller.

Parameters:
- NCH, 2, number of timer channels (1..8).
- WIDTH, 32, counter/reload width in bits (8..32).
- AW, clog2(NCH)+2, word address width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- reg_we  input  1  register write strobe, one cycle per write.
- reg_addr  input  AW  word address: [AW-1:2] = channel, [1:0] = register.
- reg_wdata  input  32  write data.
- reg_rdata  output  32  read data, combinational from reg_addr.
- irq  output  NCH  per-channel level interrupt: status & irq_en.
- evt  output  NCH  one-cycle pulse on each channel terminal event.

Behaviour:
- Per-channel registers:
  - 0 CONFIG: [0] enable, [1] oneshot, [2] up (1 = up, 0 = down), [3] chain, [4] irq_en, [15:8] prescale.
  - 1 VALUE: counter value.
  - 2 DATA: reload value (down mode) or limit (up mode).
  - 3 STATUS: [0] sticky event flag; writing 1 clears it.
- Unused bits read 0. VALUE and DATA are zero-extended to 32 bits on read; upper write bits are ignored.
- Reset: all registers 0, irq = 0, evt = 0, prescale counters 0.
- Tick for channel k (only when enable = 1):
  - chain = 0: tick on prescale expiry.
  - chain = 1, k > 0: tick = evt[k-1] in the same cycle. This is a combinational cascade with zero-cycle latency across channels.
  - chain bit on channel 0 is ignored; channel 0 uses the prescale tick.
- Prescaler: per-channel 8-bit counter runs while enable = 1. Tick when pcount == prescale, then pcount <= 0. prescale = 0 means a tick every cycle. pcount clears when enable = 0.
- Down mode, on tick:
  - VALUE != 0: VALUE <= VALUE - 1.
  - VALUE == 0: event. Continuous: VALUE <= DATA. Oneshot: VALUE holds 0 and enable clears.
- Up mode, on tick:
  - VALUE != DATA: VALUE <= VALUE + 1, wrapping modulo 2^WIDTH.
  - VALUE == DATA: event. Continuous: VALUE <= 0. Oneshot: VALUE holds DATA and enable clears.
- Event: evt[k] = 1 for exactly that cycle. STATUS[0] <= 1 on the next edge.
- Simultaneous events:
  - CPU write to VALUE in the same cycle as a tick: write wins, tick is dropped.
  - CPU write to CONFIG that clears enable in the same cycle as a tick: write wins, no event.
  - STATUS clear write in the same cycle as an event: event wins, flag stays 1.
- Writing CONFIG does not alter VALUE; enable 0→1 starts counting from the current VALUE.
- Reset asserted mid-count: all state returns to reset values on that edge; no evt pulse.

Optional Feature:
- Macro: MGMT_MULTI_TIMER_PRESCALE_EN.
- Defined: per-channel prescaler as described above.
- Undefined: no prescale counters; CONFIG[15:8] reads 0 and is not writable; every cycle with enable = 1 is a tick for unchained channels.

Test Plan:
- Ch0 down, continuous, DATA = 0x19, VALUE = 0x19, enable: evt[0] pulses every 26 cycles. STATUS = 1 after the first event; writing STATUS = 1 clears it and irq[0] drops (irq_en = 1).
- Ch0 up, oneshot, DATA = 0x0F, VALUE = 0: after 16 ticks VALUE holds 0x0F, CONFIG reads 0x06 (enable cleared), exactly one evt pulse.
- Chain: ch0 down continuous DATA = 3; ch1 down chained, VALUE = DATA = 2: ch1 decrements once per 4 cycles, and evt[1] coincides with evt[0] on every third ch0 event (period 12 cycles).
- Prescale = 4 (macro defined), ch0 down, VALUE = 10: VALUE decrements every 5 cycles, event at cycle 55. With the macro undefined, the event is at cycle 11 and CONFIG[15:8] reads 0.
- Collisions: write VALUE = 0x12BC in the cycle a tick is due → VALUE reads 0x12BC. A STATUS clear in the event cycle → STATUS stays 1.
- Reset mid-count (VALUE = 0x55) → all registers 0, irq = 0, no evt; WIDTH = 8 up continuous from 0xFF with DATA = 0x10 wraps to 0x00 and continues to 0x10.
